// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - Buffered UART transmitter, 8N1 frames fed from a small FIFO
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_buffered #(
   parameter int CLKS_PER_BIT = 6875,
   parameter int FIFO_AW      = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic               serial_out,
   output logic               Tx_en,
   output logic               baudrate_clk,
   output logic [FIFO_AW:0]   fifo_count
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int TW    = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0]    TIMER_LOAD = TW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t               state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [7:0]           shift_q, shift_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]     count_q, count_d;
   logic                 serial_q, serial_d;
   logic                 tx_en_q, tx_en_d;
   logic                 baud_q, baud_d;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif
   logic [7:0]           fifo_mem_q [DEPTH];
   logic                 push, pop, bit_done;
   logic [7:0]           head;

   assign tx_ready     = (count_q != FULL_COUNT);
   assign push         = tx_valid && tx_ready;
   assign head         = fifo_mem_q[rd_ptr_q];
   assign bit_done     = (timer_q == '0);
   assign serial_out   = serial_q;
   assign Tx_en        = tx_en_q;
   assign baudrate_clk = baud_q;
   assign fifo_count   = count_q;

   // FIFO storage carries no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= tx_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         shift_q   <= '0;
         bit_idx_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         serial_q  <= 1'b1;
         tx_en_q   <= 1'b0;
         baud_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         serial_q  <= serial_d;
         tx_en_q   <= tx_en_d;
         baud_q    <= baud_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      if (state_q != S_IDLE && !bit_done) begin
         timer_d = timer_q - 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) pop = 1'b1;
         end
         S_START: begin
            if (bit_done) begin
               state_d   = S_DATA;
               bit_idx_d = '0;
               timer_d   = TIMER_LOAD;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               timer_d = TIMER_LOAD;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_done) begin
               state_d = S_STOP;
               timer_d = TIMER_LOAD;
            end
         end
`endif
         S_STOP: begin
            // Popping here chains the next start bit straight after this stop bit.
            if (bit_done) begin
               if (count_q != '0) pop = 1'b1;
               else               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (pop) begin
         state_d = S_START;
         timer_d = TIMER_LOAD;
         shift_d = head;
`ifdef UART_TX_PARITY_EN
         parity_d = ^head;
`endif
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Outputs are decoded from the next state so the registered line moves only on bit boundaries.
   always_comb begin
      tx_en_d  = (state_d != S_IDLE);
      baud_d   = tx_en_d && (timer_d == '0);
      serial_d = 1'b1;
      case (state_d)
         S_START:  serial_d = 1'b0;
         S_DATA:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: serial_d = parity_d;
`endif
         default:  serial_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - Directed self-checking bench for uart_tx_buffered
// Runs with CLKS_PER_BIT=16; adapts frame length when UART_TX_PARITY_EN is defined.
module tb_uart_tx_buffered;

   localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       serial_out;
   logic       Tx_en;
   logic       baudrate_clk;
   logic [2:0] fifo_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_edge [6];
   int exp_gap [6];
   int b0;
   int bad;

   uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .serial_out   (serial_out),
      .Tx_en        (Tx_en),
      .baudrate_clk (baudrate_clk),
      .fifo_count   (fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on the negedge showing the first start-bit cycle; returns on the first cycle after the frame.
   task automatic frame_check(input logic [7:0] b);
      logic [10:0] bits;
`ifdef UART_TX_PARITY_EN
      bits = {1'b1, ^b, b, 1'b0};
`else
      bits = {3'b111, b, 1'b0};
`endif
      for (int k = 0; k < NB; k++) begin
         for (int c = 0; c < CPB; c++) begin
            check($sformatf("frame_%02h_bit%0d_cyc%0d", b, k, c),
                  {29'd0, serial_out, Tx_en, baudrate_clk},
                  {29'd0, bits[k], 1'b1, (c == CPB - 1)});
            @(negedge clk);
         end
      end
   endtask

   initial begin
      exp_gap = '{0, 1, 2, 3, 4, FRAME + 2};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_serial", serial_out, 1);
      check("rst_txen", Tx_en, 0);
      check("rst_baud", baudrate_clk, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ready", tx_ready, 1);
      rst = 1'b1;
      tx_data = 8'hFF;
      repeat (3) @(negedge clk);
      check("idle_ignores_data", fifo_count, 0);

      // Single byte 0xA5
      tx_data = 8'hA5;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("single_count_after_push", fifo_count, 1);
      check("single_line_before_pop", serial_out, 1);
      @(negedge clk);
      check("single_count_after_pop", fifo_count, 0);
      frame_check(8'hA5);
      check("single_idle_serial", serial_out, 1);
      check("single_idle_txen", Tx_en, 0);
      check("single_idle_baud", baudrate_clk, 0);

      // Burst of six bytes with tx_valid held
      repeat (4) @(negedge clk);
      fork
         begin : burst_push
            int wait_n;
            for (int i = 0; i < 6; i++) begin
               tx_data = 8'(i);
               tx_valid = 1'b1;
               wait_n = 0;
               while (!tx_ready && wait_n < 4 * FRAME) begin
                  @(negedge clk);
                  wait_n++;
               end
               acc_edge[i] = cyc + 1;
               @(negedge clk);
               if (i == 4) begin
                  check("burst_full_count", fifo_count, 4);
                  check("burst_full_ready", tx_ready, 0);
               end
            end
            tx_valid = 1'b0;
         end
         begin : burst_watch
            @(negedge clk);
            @(negedge clk);
            for (int f = 0; f < 6; f++) frame_check(8'(f));
         end
      join
      for (int i = 0; i < 6; i++) begin
         check($sformatf("burst_accept_edge%0d", i), acc_edge[i] - acc_edge[0], exp_gap[i]);
      end
      check("burst_end_txen", Tx_en, 0);
      check("burst_end_serial", serial_out, 1);
      check("burst_end_count", fifo_count, 0);

      // Push coinciding with the end-of-stop pop
      repeat (3) @(negedge clk);
      fork
         begin : simul_push
            b0 = cyc + 1;
            tx_data = 8'h3C; tx_valid = 1'b1;
            @(negedge clk);
            tx_data = 8'h81;
            @(negedge clk);
            tx_data = 8'h7E;
            @(negedge clk);
            tx_valid = 1'b0;
            while (cyc < b0 + FRAME) @(negedge clk);
            check("simul_count_before", fifo_count, 2);
            tx_data = 8'h99; tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            check("simul_count_after", fifo_count, 2);
            check("simul_txen", Tx_en, 1);
         end
         begin : simul_watch
            @(negedge clk);
            @(negedge clk);
            frame_check(8'h3C);
            frame_check(8'h81);
            frame_check(8'h7E);
            frame_check(8'h99);
         end
      join
      check("simul_end_count", fifo_count, 0);

      // Reset during data bit 3 of the first frame
      repeat (3) @(negedge clk);
      b0 = cyc + 1;
      tx_data = 8'h55; tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'h12;
      @(negedge clk);
      tx_data = 8'h34;
      @(negedge clk);
      tx_valid = 1'b0;
      while (cyc < b0 + 1 + 4 * CPB + 5) @(negedge clk);
      check("midrst_bit3_line", serial_out, 0);
      check("midrst_bit3_txen", Tx_en, 1);
      check("midrst_bit3_count", fifo_count, 2);
      rst = 1'b0;
      #1;
      check("midrst_serial", serial_out, 1);
      check("midrst_txen", Tx_en, 0);
      check("midrst_baud", baudrate_clk, 0);
      check("midrst_count", fifo_count, 0);
      check("midrst_ready", tx_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      tx_data = 8'hFF;
      bad = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (serial_out !== 1'b1 || Tx_en !== 1'b0 || fifo_count !== 3'd0) bad++;
      end
      check("midrst_quiet_after_release", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
